// File: rtl/sc_pkg.sv
// sc_pkg: shared types and width helpers for the stochastic-computing job sequencer.
//   state_t : sequencer FSM states
//   clog2w  : bits needed to count 0..n-1 (never less than 1)
package sc_pkg;
  typedef enum logic [2:0] {IDLE, SEED, FLUSH, RUN, DONE} state_t;
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction
endpackage

// File: rtl/sc_ones_counter.sv
// sc_ones_counter: stochastic-to-binary accumulator, counts ones while enabled.
//   clk, rst (sync, active-low), clear (sync zero), enable (count window),
//   bit_in (stochastic bit), count (ones seen, STREAM_LOG2+1 bits so 2^STREAM_LOG2 fits)
module sc_ones_counter #(
  parameter int STREAM_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [STREAM_LOG2:0] count
);
  always_ff @(posedge clk) begin
    if (!rst || clear) count <= '0;
    else if (enable && bit_in) count <= count + 1'b1;
  end
endmodule

// File: rtl/sng_sequencer.sv
// sng_sequencer: per-job controller for one SNG: seed, flush its pipeline, count N output ones.
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_value : job request handshake and operand
//   sng_rst/sng_in/sng_bit        : SNG reset (active-high), operand, stochastic bit
//   res_valid/res_ready/res_count : result handshake and ones count (0..N)
//   busy                          : high outside IDLE
module sng_sequencer
  import sc_pkg::*;
#(
  parameter int PRECISION   = 8,
  parameter int STREAM_LOG2 = 8,
  parameter int SNG_LATENCY = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [PRECISION-1:0]   req_value,
  output logic                   sng_rst,
  output logic [PRECISION-1:0]   sng_in,
  input  logic                   sng_bit,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [STREAM_LOG2:0]   res_count,
  output logic                   busy
);
  localparam int WW = clog2w(SNG_LATENCY);
  localparam int CW = STREAM_LOG2 + 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(SNG_LATENCY - 1);
  localparam logic [CW-1:0] RUN_LAST  = CW'((1 << STREAM_LOG2) - 1);
  state_t               state;
  logic [PRECISION-1:0] operand;
  logic [WW-1:0]        wait_cnt;
  logic [CW-1:0]        run_cnt;
  logic                 accept;
  assign accept = req_valid && req_ready;
  sc_ones_counter #(.STREAM_LOG2(STREAM_LOG2)) u_ones (
    .clk    (clk),
    .rst    (rst),
    .clear  (accept),
    .enable (state == RUN),
    .bit_in (sng_bit),
    .count  (res_count)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      busy      <= 1'b0;
      sng_rst   <= 1'b1;
      sng_in    <= '0;
      operand   <= '0;
      wait_cnt  <= '0;
      run_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          sng_rst <= accept;
          sng_in  <= accept ? req_value : '0;
          if (accept) begin
            operand   <= req_value;
            req_ready <= 1'b0;
            busy      <= 1'b1;
            state     <= SEED;
          end
        end
        SEED: begin
          sng_rst  <= 1'b0;
          sng_in   <= operand;
          wait_cnt <= '0;
          state    <= FLUSH;
        end
        FLUSH: begin
          sng_in   <= operand;
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_cnt == WAIT_LAST) begin
            run_cnt <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sng_in  <= operand;
          run_cnt <= run_cnt + 1'b1;
          if (run_cnt == RUN_LAST) begin
            res_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
            sng_in    <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sng_sequencer.md
Name: sng_sequencer

Overview:
- Job controller for one stochastic number generator (SNG) instance.
- Per job: accepts a binary operand, re-seeds the SNG, and holds the operand on the SNG input while the SNG pipeline fills.
- Then counts the ones in a fixed-length output stream (stochastic-to-binary conversion) and returns the count over a valid/ready handshake.
- Sits between a host/accelerator front end and the sng datapath. The SNG itself is instantiated beside this block, not inside it.

Parameters:
- PRECISION, 8, operand and LFSR width in bits; must equal the attached SNG's PRECISION.
- STREAM_LOG2, 8, log2 of stream length; stream length N = 2^STREAM_LOG2 bits.
- SNG_LATENCY, 2, cycles from SNG reset release until its first valid output bit; legal range 1..15.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset; synchronous, active-low (rst==0 resets on a clk rising edge).
- req_valid  input  1  job request valid.
- req_ready  output  1  sequencer can accept a job; high only in IDLE.
- req_value  input  PRECISION  binary operand for the job.
- sng_rst  output  1  drives the SNG's reset; active-high, as the SNG expects.
- sng_in  output  PRECISION  operand driven to the SNG input.
- sng_bit  input  1  SNG stochastic output bit.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_count  output  STREAM_LOG2+1  number of ones observed in N sampled bits (range 0..N).
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst==0 at an edge), next cycle:
  - state=IDLE
  - req_ready=1, res_valid=0, res_count=0, busy=0
  - sng_rst=1, sng_in=0
- Reset mid-job aborts the job. No result is produced, and any held result is discarded.
- Reset dominates all other inputs.
- States: IDLE, SEED, FLUSH, RUN, DONE.
- IDLE:
  - sng_rst=0, sng_in=0.
  - On an edge with req_valid && req_ready (edge T): capture req_value into an operand register, clear the ones counter, go to SEED.
- SEED, exactly one cycle (T+1):
  - sng_rst=1, sng_in=operand.
  - Next state FLUSH.
- FLUSH, SNG_LATENCY cycles (T+2 .. T+1+SNG_LATENCY):
  - sng_rst=0, sng_in=operand.
  - sng_bit is ignored.
  - A wait counter runs from 0 to SNG_LATENCY-1, then the block goes to RUN.
- RUN, N cycles (T+2+SNG_LATENCY .. T+1+SNG_LATENCY+N):
  - sng_in=operand.
  - On each edge, sng_bit is sampled and the counter adds 1 if sng_bit==1.
  - A cycle counter of STREAM_LOG2+1 bits stops after exactly N samples, then the block goes to DONE.
- DONE:
  - res_valid=1 from cycle T+2+SNG_LATENCY+N.
  - res_count holds stable while res_valid && !res_ready.
  - On the edge with res_valid && res_ready: go to IDLE; res_valid drops the next cycle.
  - req_ready rises in that same next cycle, so back-to-back jobs have one idle cycle between them.
- Arithmetic: the ones counter is STREAM_LOG2+1 bits and cannot overflow (max N). It is never saturated or truncated.
- req_value changes after acceptance have no effect; sng_in comes only from the operand register.
- req_valid asserted outside IDLE is ignored (req_ready=0). The request is not queued.
- res_count after DONE→IDLE keeps its last value until the next accept clears it; consumers must qualify it with res_valid.
- Minimum job latency, accept edge to res_valid: 2+SNG_LATENCY+N cycles. For defaults: 260.

Decomposition:
- Shared package sc_pkg holds:
  - state enum type (IDLE, SEED, FLUSH, RUN, DONE), 3 bits;
  - function clog2-style width helper for counter widths.
- One sub-module is natural: sc_ones_counter. It is a stochastic-to-binary accumulator with:
  - ports: clk, rst, clear, enable, bit_in, count;
  - parameter: STREAM_LOG2.
- The FSM, wait counter and operand register stay in sng_sequencer.

Test Plan:
Bench configuration: PRECISION=4, STREAM_LOG2=4 (N=16), SNG_LATENCY=2. sng_bit is driven by the bench model unless stated.
1. Reset and idle:
   - Stimulus: hold rst=0 for 3 cycles, then release.
   - Required: req_ready=1, busy=0, res_valid=0, res_count=0, sng_rst=1 during reset and 0 after.
2. All-ones stream:
   - Stimulus: accept req_value=4'hA at edge T; bench drives sng_bit=1 constantly.
   - Required: sng_rst=1 only in cycle T+1; sng_in=4'hA from T+1 until DONE.
   - Required: res_valid rises at cycle T+20 with res_count=16 (5'b10000, no overflow).
3. Pattern stream and flush masking:
   - Stimulus: sng_bit=1 during FLUSH cycles, then alternating 1,0 during RUN.
   - Required: res_count=8; FLUSH bits are not counted.
4. Result backpressure:
   - Stimulus: hold res_ready=0 for 10 cycles after res_valid, with req_valid=1 and a new req_value throughout.
   - Required: res_valid and res_count stable; req_ready=0; no second job starts.
   - Required: after res_ready=1 for one edge, req_ready=1 next cycle and the new job is accepted the cycle after.
5. Reset mid-RUN:
   - Stimulus: assert rst=0 for 1 cycle at RUN sample 7.
   - Required: IDLE next cycle, res_valid never asserts, res_count=0.
   - Required: the next job with sng_bit=0 gives res_count=0.
6. Real SNG integration:
   - Stimulus: connect the actual sng (PRECISION=4); run jobs with req_value=0 and req_value=4'hF.
   - Required: counts are monotonic in operand; count for 0 ≤ count for 4'hF.
   - Required: results match the bench's LFSR/comparator reference model bit-exactly.
